// File: rtl/ifu_prefetch_queue.sv
// ifu_prefetch_queue
// Instruction-fetch front end. It sits between the IF stage and a 1-cycle-latency instruction SRAM.
// It issues sequential fetches ahead of decode and buffers each returned word, together with its PC,
// in a DEPTH-entry circular queue. Decode drains the queue over a valid/ready handshake.
// A redirect flushes the queue and any in-flight fetch, then restarts fetch at the new target.
//
// Handshake: a head entry moves to decode in any cycle where out_valid & out_ready are both high.
// out_valid does not depend on out_ready. out_pc and out_inst hold steady while out_valid is high
// and out_ready is low.
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   inst_sram_*      SRAM fetch port. en/addr are the request; rdata returns one cycle later.
//                    wen and wdata are tied to zero.
//   redirect_valid/pc  flush and refetch from pc. pc bits [1:0] are ignored.
//   out_valid/ready/pc/inst  head-of-queue handshake toward decode
//   fill_level       number of occupied queue entries
module ifu_prefetch_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 'hBFC00000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_wen,
  output logic [ADDR_W-1:0]          inst_sram_addr,
  output logic [DATA_W-1:0]          inst_sram_wdata,
  input  logic [DATA_W-1:0]          inst_sram_rdata,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]     fill_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic [ADDR_W-1:0] mem_pc   [DEPTH];
  logic [DATA_W-1:0] mem_inst [DEPTH];

  logic              pop;
  logic              wr_en;
  logic              issue;
  logic [CW:0]       occ;
  logic [ADDR_W-1:0] redirect_addr;
  logic [ADDR_W-1:0] issue_addr;

  assign redirect_addr = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Count is zero during reset, so out_valid is low then as well.
  assign out_valid = (count_q != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;

  // Entries that are occupied or already promised to the in-flight word after this cycle's pop.
  // Issuing only below DEPTH reserves a slot for every returning word.
  assign occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign issue = !reset && (redirect_valid || (occ < DEPTH_C));

  // The response to the previous request is written unless a redirect discards it.
  assign wr_en = inflight_q && !redirect_valid;

  assign issue_addr      = redirect_valid ? redirect_addr : fetch_pc_q;
  assign inst_sram_en    = issue;
  assign inst_sram_addr  = issue_addr;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = '0;

  assign out_pc     = mem_pc[rd_ptr_q];
  assign out_inst   = mem_inst[rd_ptr_q];
  assign fill_level = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (issue) begin
      fetch_pc_d    = issue_addr + ADDR_W'(4);
      inflight_pc_d = issue_addr;
    end
    if (redirect_valid) begin
      // Drop every buffered entry by moving the read pointer up to the write pointer.
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      count_d = count_q + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // The queue storage needs no reset. Count and the pointers decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      mem_pc[wr_ptr_q]   <= inflight_pc_q;
      mem_inst[wr_ptr_q] <= inst_sram_rdata;
    end
  end

endmodule
